reg_unit_wb: RTL and testbench

Register unit with integrated write-back selection for the single-cycle RV32I core. It supplies the two source operands RUrs1/RUrs2 that feed the ALU operand muxes. It also closes the loop by selecting the result to commit (ALU result, load data or PC+4) and writing it into the 32×32 register array on the clock edge. A debug read port and a committed-write counter support bench and board-level observation.

---
 rtl/reg_unit_wb.sv | 59 +++++
 tb/tb_reg_unit_wb.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/reg_unit_wb.sv
// Register unit for the single-cycle RV32I core: 32x32 array, write-back source mux,
// asynchronous operand/debug reads and a committed-write counter.
module reg_unit_wb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [$clog2(NREGS)-1:0] rs1,
    input  logic [$clog2(NREGS)-1:0] rs2,
    input  logic [$clog2(NREGS)-1:0] rd,
    input  logic                     RUWr,
    input  logic [1:0]               RUDataWrSrc,
    input  logic [XLEN-1:0]          ALURes,
    input  logic [XLEN-1:0]          DataRd,
    input  logic [XLEN-1:0]          PcInc,
    input  logic [$clog2(NREGS)-1:0] DbgAddr,
    output logic [XLEN-1:0]          RUrs1,
    output logic [XLEN-1:0]          RUrs2,
    output logic [XLEN-1:0]          DbgData,
    output logic [XLEN-1:0]          WbData,
    output logic [31:0]              WrCount
);

    logic [XLEN-1:0] regs [NREGS];
    logic [31:0]     wr_count;
    logic            commit;

    always_comb begin
        WbData = '0;
        unique case (RUDataWrSrc)
            2'b00:   WbData = ALURes;
            2'b01:   WbData = DataRd;
            2'b10:   WbData = PcInc;
            default: WbData = '0;
        endcase
    end

    assign commit = RUWr && (rd != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            wr_count <= '0;
        end else if (commit) begin
            regs[rd] <= WbData;
            wr_count <= wr_count + 32'd1;
        end
    end

    // x0 is forced to zero on the read side so it never depends on array contents.
    assign RUrs1   = (rs1 == '0)     ? '0 : regs[rs1];
    assign RUrs2   = (rs2 == '0)     ? '0 : regs[rs2];
    assign DbgData = (DbgAddr == '0) ? '0 : regs[DbgAddr];
    assign WrCount = wr_count;

endmodule

// File: tb/tb_reg_unit_wb.sv
// Directed self-checking bench for reg_unit_wb: reset, source select, x0, bypass,
// write-enable, full sweep and counter wrap.
module tb_reg_unit_wb;

    logic        clk;
    logic        rst;
    logic [4:0]  rs1, rs2, rd, DbgAddr;
    logic        RUWr;
    logic [1:0]  RUDataWrSrc;
    logic [31:0] ALURes, DataRd, PcInc;
    logic [31:0] RUrs1, RUrs2, DbgData, WbData, WrCount;

    int n_cmp;
    int n_fail;

    reg_unit_wb #(.XLEN(32), .NREGS(32)) dut (
        .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .rd(rd), .RUWr(RUWr),
        .RUDataWrSrc(RUDataWrSrc), .ALURes(ALURes), .DataRd(DataRd), .PcInc(PcInc),
        .DbgAddr(DbgAddr), .RUrs1(RUrs1), .RUrs2(RUrs2), .DbgData(DbgData),
        .WbData(WbData), .WrCount(WrCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_state();
        n_cmp++;
        if (RUrs1 !== 32'h0) begin n_fail++; $display("FAIL reset_rurs1: got %h want %h", RUrs1, 32'h0); end
        n_cmp++;
        if (RUrs2 !== 32'h0) begin n_fail++; $display("FAIL reset_rurs2: got %h want %h", RUrs2, 32'h0); end
        n_cmp++;
        if (DbgData !== 32'h0) begin n_fail++; $display("FAIL reset_dbg: got %h want %h", DbgData, 32'h0); end
        n_cmp++;
        if (WrCount !== 32'h0) begin n_fail++; $display("FAIL reset_count: got %h want %h", WrCount, 32'h0); end
    endtask

    task automatic test_source_select();
        logic [31:0] exp_v [4];
        exp_v[0] = 32'h11; exp_v[1] = 32'h22; exp_v[2] = 32'h104; exp_v[3] = 32'h0;
        ALURes = 32'h11; DataRd = 32'h22; PcInc = 32'h104;
        rd = 5'd3; rs1 = 5'd3; RUWr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            RUDataWrSrc = 2'(i);
            #1;
            n_cmp++;
            if (WbData !== exp_v[i]) begin n_fail++; $display("FAIL wbdata_sel%0d: got %h want %h", i, WbData, exp_v[i]); end
            tick();
            n_cmp++;
            if (RUrs1 !== exp_v[i]) begin n_fail++; $display("FAIL srcsel_x3_%0d: got %h want %h", i, RUrs1, exp_v[i]); end
        end
        RUWr = 1'b0;
        n_cmp++;
        if (WrCount !== 32'd4) begin n_fail++; $display("FAIL srcsel_count: got %0d want %0d", WrCount, 4); end
    endtask

    task automatic test_x0();
        RUDataWrSrc = 2'b00; ALURes = 32'hFFFF_FFFF; rd = 5'd0; RUWr = 1'b1; rs1 = 5'd0;
        tick();
        RUWr = 1'b0;
        n_cmp++;
        if (RUrs1 !== 32'h0) begin n_fail++; $display("FAIL x0_read: got %h want %h", RUrs1, 32'h0); end
        n_cmp++;
        if (WrCount !== 32'd4) begin n_fail++; $display("FAIL x0_count: got %0d want %0d", WrCount, 4); end
    endtask

    task automatic test_no_bypass();
        RUDataWrSrc = 2'b00; ALURes = 32'hA5A5_A5A5; rd = 5'd7; rs1 = 5'd7; rs2 = 5'd7; RUWr = 1'b1;
        #1;
        n_cmp++;
        if (RUrs1 !== 32'h0) begin n_fail++; $display("FAIL bypass_pre_rs1: got %h want %h", RUrs1, 32'h0); end
        n_cmp++;
        if (RUrs2 !== 32'h0) begin n_fail++; $display("FAIL bypass_pre_rs2: got %h want %h", RUrs2, 32'h0); end
        tick();
        RUWr = 1'b0;
        n_cmp++;
        if (RUrs1 !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL bypass_post_rs1: got %h want %h", RUrs1, 32'hA5A5_A5A5); end
        n_cmp++;
        if (RUrs2 !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL bypass_post_rs2: got %h want %h", RUrs2, 32'hA5A5_A5A5); end
        n_cmp++;
        if (WrCount !== 32'd5) begin n_fail++; $display("FAIL bypass_count: got %0d want %0d", WrCount, 5); end
    endtask

    task automatic test_ruwr_low();
        RUDataWrSrc = 2'b00; ALURes = 32'h55; rd = 5'd9; RUWr = 1'b0; rs1 = 5'd9; DbgAddr = 5'd9;
        tick();
        n_cmp++;
        if (RUrs1 !== 32'h0) begin n_fail++; $display("FAIL ruwr_low_x9: got %h want %h", RUrs1, 32'h0); end
        n_cmp++;
        if (DbgData !== 32'h0) begin n_fail++; $display("FAIL ruwr_low_dbg: got %h want %h", DbgData, 32'h0); end
        n_cmp++;
        if (WrCount !== 32'd5) begin n_fail++; $display("FAIL ruwr_low_count: got %0d want %0d", WrCount, 5); end
    endtask

    task automatic test_async_reset();
        RUDataWrSrc = 2'b00; ALURes = 32'hDEAD_BEEF; rd = 5'd5; rs1 = 5'd5; RUWr = 1'b1;
        tick();
        RUWr = 1'b0;
        n_cmp++;
        if (RUrs1 !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rst_pre_x5: got %h want %h", RUrs1, 32'hDEAD_BEEF); end
        n_cmp++;
        if (WrCount !== 32'd6) begin n_fail++; $display("FAIL rst_pre_count: got %0d want %0d", WrCount, 6); end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (RUrs1 !== 32'h0) begin n_fail++; $display("FAIL rst_async_x5: got %h want %h", RUrs1, 32'h0); end
        n_cmp++;
        if (WrCount !== 32'h0) begin n_fail++; $display("FAIL rst_async_count: got %0d want %0d", WrCount, 0); end
        // a write presented while reset is held must be lost
        RUWr = 1'b1; ALURes = 32'h1234;
        tick();
        n_cmp++;
        if (RUrs1 !== 32'h0) begin n_fail++; $display("FAIL rst_held_x5: got %h want %h", RUrs1, 32'h0); end
        RUWr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_sweep();
        logic [31:0] exp_v;
        RUDataWrSrc = 2'b00; RUWr = 1'b1;
        for (int i = 1; i < 32; i++) begin
            rd = 5'(i);
            ALURes = 32'(i) * 32'h0101_0101;
            tick();
        end
        RUWr = 1'b0;
        for (int i = 0; i < 32; i++) begin
            DbgAddr = 5'(i);
            exp_v = 32'(i) * 32'h0101_0101;
            #1;
            n_cmp++;
            if (DbgData !== exp_v) begin n_fail++; $display("FAIL sweep_x%0d: got %h want %h", i, DbgData, exp_v); end
        end
        n_cmp++;
        if (WrCount !== 32'd31) begin n_fail++; $display("FAIL sweep_count: got %0d want %0d", WrCount, 31); end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        force dut.wr_count = 32'hFFFF_FFFF;
        #1;
        release dut.wr_count;
        n_cmp++;
        if (WrCount !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_preload: got %h want %h", WrCount, 32'hFFFF_FFFF); end
        RUDataWrSrc = 2'b10; PcInc = 32'h200; rd = 5'd10; RUWr = 1'b1;
        tick();
        n_cmp++;
        if (WrCount !== 32'h0) begin n_fail++; $display("FAIL wrap_zero: got %h want %h", WrCount, 32'h0); end
        rd = 5'd10;
        tick();
        RUWr = 1'b0;
        n_cmp++;
        if (WrCount !== 32'h1) begin n_fail++; $display("FAIL wrap_one: got %h want %h", WrCount, 32'h1); end
        DbgAddr = 5'd10;
        #1;
        n_cmp++;
        if (DbgData !== 32'h200) begin n_fail++; $display("FAIL wrap_x10: got %h want %h", DbgData, 32'h200); end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        rst = 1'b1; rs1 = '0; rs2 = '0; rd = '0; DbgAddr = '0; RUWr = 1'b0;
        RUDataWrSrc = 2'b00; ALURes = '0; DataRd = '0; PcInc = '0;
        #12;
        test_reset_state();
        @(negedge clk);
        rst = 1'b0;
        #1;
        test_source_select();
        test_x0();
        test_no_bypass();
        test_ruwr_low();
        test_async_reset();
        test_reset_state();
        test_sweep();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
